// File: rtl/key_link_pkg.sv
// rtl/key_link_pkg.sv - shared types, constants and baud divisor helper for the key link
package key_link_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam logic [7:0] KEY_NONE = 8'h00;

   // Cycles per bit, truncated; the receiver uses the same rounding so both ends agree.
   function automatic int calc_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/key_link_tx_if.sv
// rtl/key_link_tx_if.sv - key code input and serial line outputs of the key link transmitter
interface key_link_tx_if;
   logic [7:0]  key_in;
   logic        tx;
   logic        busy;
   logic        frame_done;
   logic [15:0] frames_sent;

   modport master (
      output key_in,
      input  tx,
      input  busy,
      input  frame_done,
      input  frames_sent
   );

   modport slave (
      input  key_in,
      output tx,
      output busy,
      output frame_done,
      output frames_sent
   );
endinterface

// File: rtl/key_link_tx_baud_gen.sv
// rtl/key_link_tx_baud_gen.sv - DIV-cycle bit timer with synchronous clear and bit_end strobe
module baud_gen #(
   parameter int DIV = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   output logic bit_end_o
);

   localparam int CW = $clog2(DIV);

   logic [CW-1:0] cnt_q, cnt_d;

   assign bit_end_o = (cnt_q == CW'(DIV - 1));

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr_i || bit_end_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/key_link_tx.sv
// rtl/key_link_tx.sv - sends the local key code as 8N1 UART frames on change and on a repeat timer
module key_link_tx
   import key_link_pkg::*;
#(
   parameter int CLK_HZ        = 65_000_000,
   parameter int BAUD          = 9600,
   parameter int REPEAT_CYCLES = 6_500_000
) (
   input  logic          pclk,
   input  logic          rst,
   key_link_tx_if.slave  link
);

   localparam int DIV    = calc_div(CLK_HZ, BAUD);
   localparam bit REP_EN = (REPEAT_CYCLES > 0);
   localparam int RW     = REP_EN ? $clog2(REPEAT_CYCLES + 1) : 1;
   localparam logic [RW-1:0] REP_LAST = RW'(REP_EN ? REPEAT_CYCLES - 1 : 0);

   localparam logic [1:0] S_IDLE  = 2'(IDLE);
   localparam logic [1:0] S_START = 2'(START);
   localparam logic [1:0] S_DATA  = 2'(DATA);
   localparam logic [1:0] S_STOP  = 2'(STOP);

   logic [1:0]    state_q, state_d;
   logic [7:0]    key_q;
   logic [7:0]    last_q, last_d;
   logic [7:0]    pend_q, pend_d;
   logic          pend_valid_q, pend_valid_d;
   logic [7:0]    shift_q, shift_d;
   logic [2:0]    bit_q, bit_d;
   logic [RW-1:0] rep_q, rep_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [15:0]   sent_q, sent_d;

   logic          bit_end;
   logic          baud_clr;
   logic          change;
   logic          expire;
   logic          launch;
   logic [7:0]    launch_byte;

   baud_gen #(
      .DIV (DIV)
   ) u_baud (
      .clk_i     (pclk),
      .rst_ni    (rst),
      .clr_i     (baud_clr),
      .bit_end_o (bit_end)
   );

   assign change   = (key_q != last_q);
   assign expire   = REP_EN && (state_q == S_IDLE) && (rep_q == REP_LAST);
   assign baud_clr = (state_q == S_IDLE) || (state_d != state_q);

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bit_d        = bit_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      last_d       = change ? key_q : last_q;
      done_d       = 1'b0;
      sent_d       = sent_q;
      launch       = 1'b0;
      launch_byte  = change ? key_q : pend_q;

      case (state_q)
         S_IDLE: begin
            if (change || pend_valid_q) begin
               launch = 1'b1;
            end else if (expire) begin
               launch      = 1'b1;
               launch_byte = last_q;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end
         end
         S_STOP: begin
            if (bit_end) begin
               done_d = 1'b1;
               sent_d = sent_q + 16'd1;
               // A change landing in the final stop cycle still chains without an idle gap.
               if (change || pend_valid_q) begin
                  launch = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (launch) begin
         state_d      = S_START;
         shift_d      = launch_byte;
         pend_valid_d = 1'b0;
      end else if (change) begin
         pend_d       = key_q;
         pend_valid_d = 1'b1;
      end

      if (state_d != state_q) begin
         bit_d = 3'd0;
      end
   end

   always_comb begin
      rep_d = rep_q;
      if (launch) begin
         rep_d = '0;
      end else if (REP_EN && (state_q == S_IDLE)) begin
         rep_d = rep_q + RW'(1);
      end
   end

   // Line level follows the next state so tx and busy change on the same edge as the FSM.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         key_q        <= KEY_NONE;
         last_q       <= KEY_NONE;
         pend_q       <= KEY_NONE;
         pend_valid_q <= 1'b0;
         shift_q      <= 8'hFF;
         bit_q        <= 3'd0;
         rep_q        <= '0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         sent_q       <= 16'd0;
      end else begin
         state_q      <= state_d;
         key_q        <= link.key_in;
         last_q       <= last_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         shift_q      <= shift_d;
         bit_q        <= bit_d;
         rep_q        <= rep_d;
         tx_q         <= tx_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         sent_q       <= sent_d;
      end
   end

   assign link.tx          = tx_q;
   assign link.busy        = busy_q;
   assign link.frame_done  = done_q;
   assign link.frames_sent = sent_q;

endmodule

// File: tb/tb_key_link_tx.sv
// tb/tb_key_link_tx.sv - scoreboard bench for key_link_tx with DIV=10 and a 300-cycle repeat
module tb_key_link_tx;
   import key_link_pkg::*;

   logic pclk = 1'b0;
   logic rst  = 1'b0;

   key_link_tx_if link ();

   key_link_tx #(
      .CLK_HZ        (1000),
      .BAUD          (100),
      .REPEAT_CYCLES (300)
   ) dut (
      .pclk (pclk),
      .rst  (rst),
      .link (link)
   );

   always #5 pclk = ~pclk;

   int checks   = 0;
   int failures = 0;
   logic [7:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Counts cycles of a quiet line (tx high, busy low) starting at the current negedge.
   task automatic idle_run(output int n);
      n = 0;
      while (link.tx === 1'b1 && link.busy === 1'b0 && n < 1000) begin
         n++;
         @(negedge pclk);
      end
   endtask

   // Called at the negedge of the first start-bit cycle; returns at the negedge 100 cycles later.
   task automatic expect_wave(input logic [7:0] b, input string tag);
      int errs;
      logic exp_tx;
      errs = 0;
      for (int k = 0; k < 100; k++) begin
         if (k < 10)      exp_tx = 1'b0;
         else if (k < 90) exp_tx = b[k/10 - 1];
         else             exp_tx = 1'b1;
         if (link.tx !== exp_tx || link.busy !== 1'b1) errs++;
         if (k > 0 && link.frame_done !== 1'b0) errs++;
         @(negedge pclk);
      end
      check_eq(tag, errs, 0);
   endtask

   initial begin : monitor
      logic [7:0] b;
      logic st, sp, ab;
      forever begin
         @(negedge pclk);
         if (rst === 1'b1 && link.tx === 1'b0) begin
            ab = 1'b0; st = 1'b1; sp = 1'b0; b = 8'h00;
            for (int k = 1; k < 100; k++) begin
               @(negedge pclk);
               if (rst !== 1'b1) ab = 1'b1;
               if (k == 4) st = link.tx;
               else if (k % 10 == 4 && k < 90) b[k/10 - 1] = link.tx;
               else if (k == 94) sp = link.tx;
            end
            if (!ab) begin
               check_eq("mon_start_bit", st, 0);
               check_eq("mon_stop_bit", sp, 1);
               check_eq("mon_frame_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) check_eq("mon_byte", b, exp_q.pop_front());
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog timeout");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

   initial begin : main
      int n;
      int errs;
      link.key_in = 8'h00;
      rst = 1'b0;
      repeat (3) @(negedge pclk);
      check_eq("rst_tx", link.tx, 1);
      check_eq("rst_busy", link.busy, 0);
      check_eq("rst_done", link.frame_done, 0);
      check_eq("rst_sent", link.frames_sent, 0);

      // Idle key after reset only goes out on repeat expiry.
      exp_q.push_back(8'h00);
      rst = 1'b1;
      idle_run(n);
      check_eq("rst_idle_cycles", n, 300);
      expect_wave(8'h00, "wave_00");
      check_eq("done_00", link.frame_done, 1);
      check_eq("sent_00", link.frames_sent, 1);

      link.key_in = 8'hA5;
      exp_q.push_back(8'hA5);
      @(negedge pclk);
      check_eq("a5_latency_high", link.tx, 1);
      @(negedge pclk);
      expect_wave(8'hA5, "wave_a5");
      check_eq("done_a5", link.frame_done, 1);
      check_eq("sent_a5", link.frames_sent, 2);

      // Two changes during a frame: only the latest is queued.
      link.key_in = 8'h11;
      exp_q.push_back(8'h11);
      repeat (2) @(negedge pclk);
      repeat (20) @(negedge pclk);
      link.key_in = 8'h22;
      repeat (20) @(negedge pclk);
      link.key_in = 8'h33;
      exp_q.push_back(8'h33);
      repeat (60) @(negedge pclk);
      check_eq("b2b_tx_start", link.tx, 0);
      check_eq("b2b_done", link.frame_done, 1);
      check_eq("b2b_sent", link.frames_sent, 3);
      expect_wave(8'h33, "wave_33");
      check_eq("sent_33", link.frames_sent, 4);

      link.key_in = 8'h07;
      exp_q.push_back(8'h07);
      repeat (2) @(negedge pclk);
      expect_wave(8'h07, "wave_07");
      for (int r = 0; r < 2; r++) begin
         check_eq("rep_done", link.frame_done, 1);
         exp_q.push_back(8'h07);
         idle_run(n);
         check_eq("rep_idle_cycles", n, 300);
         expect_wave(8'h07, "wave_07_rep");
      end
      check_eq("sent_rep", link.frames_sent, 7);

      // Reset mid-frame with a pending byte queued.
      link.key_in = 8'h5A;
      repeat (2) @(negedge pclk);
      repeat (20) @(negedge pclk);
      link.key_in = 8'h66;
      repeat (20) @(negedge pclk);
      rst = 1'b0;
      link.key_in = 8'h00;
      #1;
      check_eq("abort_tx_async", link.tx, 1);
      check_eq("abort_busy_async", link.busy, 0);
      errs = 0;
      repeat (10) begin
         @(negedge pclk);
         if (link.frame_done !== 1'b0) errs++;
      end
      check_eq("abort_no_done", errs, 0);
      check_eq("abort_sent", link.frames_sent, 0);
      exp_q.push_back(8'h00);
      rst = 1'b1;
      idle_run(n);
      check_eq("abort_no_pending", n, 300);
      expect_wave(8'h00, "wave_00_post");
      check_eq("sent_post", link.frames_sent, 1);

      // Counter wrap.
      force dut.sent_q = 16'hFFFF;
      @(negedge pclk);
      release dut.sent_q;
      check_eq("wrap_preload", link.frames_sent, 16'hFFFF);
      link.key_in = 8'hC3;
      exp_q.push_back(8'hC3);
      repeat (2) @(negedge pclk);
      expect_wave(8'hC3, "wave_c3");
      check_eq("wrap_done", link.frame_done, 1);
      check_eq("wrap_sent", link.frames_sent, 0);

      repeat (5) @(negedge pclk);
      check_eq("sb_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
